// File: rtl/mem_burst_pkg.sv
// Shared types and default geometry for the cache-line to memory-burst adapter.
package mem_burst_pkg;

  // Default burst geometry: four 64-bit beats make one 256-bit cache line.
  localparam int BEAT_W_DEF = 64;
  localparam int BEATS_DEF  = 4;
  localparam int LINE_W_DEF = BEAT_W_DEF * BEATS_DEF;

  // Burst sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_burst_adapter.sv
// Converts single-cycle cache line fill/writeback requests into multi-beat
// memory bursts. The beat counter and line buffers live inline in this module.
module mem_burst_adapter
  import mem_burst_pkg::*;
#(
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int BEATS  = BEATS_DEF,
  localparam int LINE_W = BEAT_W * BEATS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       line_addr_i,
  input  logic              line_read_i,
  input  logic              line_write_i,
  input  logic [LINE_W-1:0] line_wdata_i,
  output logic [LINE_W-1:0] line_rdata_o,
  output logic              line_resp_o,
  output logic [31:0]       mem_addr_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [BEAT_W-1:0] mem_wdata_o,
  input  logic [BEAT_W-1:0] mem_rdata_i,
  input  logic              mem_resp_i
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  // Line offset bits [4:0] are dropped so the burst always starts line-aligned.
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFE0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  int                beat_base;

  // State, counter and line buffers; reset clears everything so a burst aborts at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: latch a request in IDLE (write wins), count accepted beats, wrap on the last.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    beat_base = int'(cnt_q) * BEAT_W;
    case (state_q)
      IDLE: begin
        if (line_write_i) begin
          addr_d  = line_addr_i & ADDR_MASK;
          wdata_d = line_wdata_i;
          cnt_d   = '0;
          state_d = WRITE;
        end else if (line_read_i) begin
          addr_d  = line_addr_i & ADDR_MASK;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (mem_resp_i) begin
          rdata_d[beat_base +: BEAT_W] = mem_rdata_i;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        if (mem_resp_i) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_read_o   = (state_q == READ);
  assign mem_write_o  = (state_q == WRITE);
  assign line_resp_o  = (state_q == DONE);
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q[int'(cnt_q) * BEAT_W +: BEAT_W];
  assign line_rdata_o = rdata_q;

endmodule

// File: doc/mem_burst_adapter.md
MEM_BURST_ADAPTER -- requirements
Module: mem_burst_adapter

Interface
REQ-001 Parameter BEAT_W, default 64: width in bits of one memory burst beat.
REQ-002 Parameter BEATS, default 4: number of beats per line; LINE_W = BEAT_W*BEATS, 256 by default.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 line_addr_i  in  32  cache-side line address; bits [4:0] ignored.
REQ-006 line_read_i  in  1  cache requests a line fill.
REQ-007 line_write_i  in  1  cache requests a line writeback.
REQ-008 line_wdata_i  in  LINE_W  line to write back; beat k = bits [k*BEAT_W +: BEAT_W].
REQ-009 line_rdata_o  out  LINE_W  assembled fill line.
REQ-010 line_resp_o  out  1  one-cycle completion pulse to the cache.
REQ-011 mem_addr_o  out  32  burst address to ParamMemory, always {line_addr[31:5],5'b0}.
REQ-012 mem_read_o  out  1  burst read request.
REQ-013 mem_write_o  out  1  burst write request.
REQ-014 mem_wdata_o  out  BEAT_W  current write beat.
REQ-015 mem_rdata_i  in  BEAT_W  current read beat.
REQ-016 mem_resp_i  in  1  beat-valid / beat-accepted strobe from memory.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WRITE and DONE.
REQ-018 In IDLE, if line_write_i=1 the FSM SHALL latch address and line_wdata_i and go to WRITE; otherwise, if line_read_i=1, it SHALL latch the address and go to READ. Write wins when both are asserted.
REQ-019 In READ, mem_read_o SHALL be 1 and mem_write_o 0; each cycle with mem_resp_i=1 SHALL store mem_rdata_i into beat slot cnt and increment the 2-bit beat counter cnt.
REQ-020 In WRITE, mem_write_o SHALL be 1 and mem_wdata_o SHALL equal latched beat cnt; each cycle with mem_resp_i=1 SHALL increment cnt.
REQ-021 On the mem_resp_i cycle with cnt=BEATS-1, the FSM SHALL go to DONE, drop its request in the next cycle, and reset cnt to 0 (wrap).
REQ-022 In DONE, line_resp_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE. Latency from the last beat to line_resp_o is 1 cycle.
REQ-023 line_rdata_o SHALL hold the last assembled line until the next READ overwrites it; the line is valid whenever line_resp_o=1 after a READ.
REQ-024 Requests seen in DONE SHALL be ignored; the cache holds its request and it is accepted in the following IDLE cycle.
REQ-025 mem_resp_i in IDLE or DONE SHALL be ignored and SHALL NOT change cnt.
REQ-026 Changes to line_addr_i, line_wdata_i or the request inputs during READ/WRITE SHALL NOT affect the burst in flight.
REQ-027 Beats need not be consecutive: gaps with mem_resp_i=0 SHALL hold cnt and the request outputs.

Reset
REQ-028 While rst_n=0, the FSM SHALL be IDLE and cnt=0. mem_read_o, mem_write_o and line_resp_o SHALL be 0. mem_addr_o, mem_wdata_o and line_rdata_o SHALL be all-zero.
REQ-029 Reset asserted mid-burst SHALL abort immediately: outputs are as in REQ-028 and no line_resp_o is produced for the aborted request.

Structure
REQ-030 The state enum and the BEAT_W, BEATS and LINE_W defaults SHALL live in the shared package mem_burst_pkg.
REQ-031 The design SHALL be a single module with no sub-modules; the beat counter and line buffer are inline.

Verification
REQ-032 Read: line_read_i=1, addr 0x0000_1234, 4 back-to-back beats 0x11..,0x22..,0x33..,0x44.. -> mem_addr_o=0x0000_1220; line_rdata_o={0x44..,0x33..,0x22..,0x11..}; line_resp_o 1 cycle after beat 4.
REQ-033 Write: line_wdata_i=256'hA..D with beats A,B,C,D; mem_resp_i held high 4 cycles -> mem_wdata_o sequence A,B,C,D; mem_write_o drops after beat 4; single line_resp_o pulse.
REQ-034 Gapped read: mem_resp_i pattern 1,0,0,1,0,1,1 -> same assembled line as the back-to-back read; mem_read_o held high throughout.
REQ-035 Simultaneous line_read_i=1 and line_write_i=1 -> mem_write_o=1 and mem_read_o=0 for the whole burst.
REQ-036 rst_n pulled low after beat 2 of a read -> outputs zero the same cycle; no line_resp_o; a fresh read afterwards completes correctly with cnt starting at 0.
